// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch handshake, redirect handshake and next-PC select
// bundle for pc_sequencer.
//   master (sequencer): drives imem_req, pc_out, redir_ready, s1, s0, flush
//   slave  (environment): drives en, imem_ack, jump/jr/br requests
interface pc_sequencer_if #(parameter int WIDTH = 32);
  logic             en;
  logic             imem_req;
  logic             imem_ack;
  logic [WIDTH-1:0] pc_out;
  logic             jump_valid;
  logic [WIDTH-1:0] jump_target;
  logic             jr_valid;
  logic [WIDTH-1:0] jr_target;
  logic             br_valid;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             redir_ready;
  logic             s1;
  logic             s0;
  logic             flush;

  modport master (
    input  en, imem_ack, jump_valid, jump_target, jr_valid, jr_target,
           br_valid, br_taken, br_target,
    output imem_req, pc_out, redir_ready, s1, s0, flush
  );

  modport slave (
    output en, imem_ack, jump_valid, jump_target, jr_valid, jr_target,
           br_valid, br_taken, br_target,
    input  imem_req, pc_out, redir_ready, s1, s0, flush
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, runs the instruction fetch handshake and
// produces the registered next-PC select code {s1,s0}
// (00 seq PC+4, 01 branch, 10 jr, 11 jump).
//   clk, rst_n : clock, async active-low reset
//   bus        : pc_sequencer_if.master (fetch + redirect handshakes)
// Redirects are taken through a one-entry pending buffer; redir_ready is
// simply "buffer empty".
module pc_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic { IDLE = 1'b0, FETCH = 1'b1 } state_t;

  typedef struct packed {
    logic [1:0]       code;
    logic [WIDTH-1:0] tgt;
  } redir_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] pc;
  logic [1:0]       sel;
  logic             flush_q;
  logic             pend_vld;
  redir_t           pend;

  redir_t req_in, src;
  logic   req_hit, acc, ack, apply;

  // Priority pick among the redirect requests; losers are dropped.
  always_comb begin
    req_in  = '{code: 2'b00, tgt: '0};
    req_hit = 1'b0;
    if (bus.jump_valid) begin
      req_in  = '{code: 2'b11, tgt: bus.jump_target};
      req_hit = 1'b1;
    end else if (bus.jr_valid) begin
      req_in  = '{code: 2'b10, tgt: bus.jr_target};
      req_hit = 1'b1;
    end else if (bus.br_valid && bus.br_taken) begin
      req_in  = '{code: 2'b01, tgt: bus.br_target};
      req_hit = 1'b1;
    end
  end

  assign acc = req_hit & ~pend_vld;
  // imem_ack only means something while a request is outstanding.
  assign ack = (state == FETCH) & bus.imem_ack;

  // PC update source: pending buffer first, then a same-cycle redirect,
  // else sequential. In IDLE a pending redirect is applied without a fetch.
  always_comb begin
    src   = '{code: 2'b00, tgt: pc + WIDTH'(4)};
    apply = 1'b0;
    if (state == FETCH) begin
      if (ack) begin
        apply = 1'b1;
        if (pend_vld) src = pend;
        else if (acc) src = req_in;
      end
    end else if (pend_vld) begin
      apply = 1'b1;
      src   = pend;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.en) state_d = FETCH;
      FETCH:   if (ack && !bus.en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      sel      <= 2'b00;
      flush_q  <= 1'b0;
      pend_vld <= 1'b0;
      pend     <= '{code: 2'b00, tgt: '0};
    end else begin
      if (apply) begin
        pc      <= src.tgt & ~WIDTH'(3);
        sel     <= src.code;
        flush_q <= |src.code;
      end else begin
        flush_q <= 1'b0;
      end
      // A redirect applied straight from the inputs never enters the buffer.
      if (apply && pend_vld) begin
        pend_vld <= 1'b0;
      end else if (acc && !apply) begin
        pend_vld <= 1'b1;
        pend     <= req_in;
      end
    end
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.pc_out      = pc;
  assign bus.redir_ready = ~pend_vld;
  assign bus.s1          = sel[1];
  assign bus.s0          = sel[0];
  assign bus.flush       = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each fetch completion pushes the expected
// {pc, sel, flush} into a scoreboard queue, popped after the update edge.
module tb_pc_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  sel;
    logic        fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   ncmp = 0;
  int   nerr = 0;
  exp_t sb[$];

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0100)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // nwait idle request cycles, then one ack cycle; check the PC update.
  task automatic fetch(input int nwait, input logic [31:0] epc,
                       input logic [1:0] esel, input logic efl);
    exp_t e;
    for (int i = 0; i < nwait; i++) begin
      step();
      chk("req_wait", {31'b0, bus.imem_req}, 32'd1);
    end
    chk("req_at_ack", {31'b0, bus.imem_req}, 32'd1);
    bus.imem_ack = 1'b1;
    sb.push_back('{pc: epc, sel: esel, fl: efl});
    step();
    bus.imem_ack = 1'b0;
    if (sb.size() == 0) begin
      ncmp++;
      nerr++;
      $error("FAIL sb_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      chk("pc", bus.pc_out, e.pc);
      chk("sel", {30'b0, bus.s1, bus.s0}, {30'b0, e.sel});
      chk("flush", {31'b0, bus.flush}, {31'b0, e.fl});
    end
  endtask

  task automatic clr_redir();
    bus.jump_valid = 1'b0;
    bus.jr_valid   = 1'b0;
    bus.br_valid   = 1'b0;
    bus.br_taken   = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.en          = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.jump_target = '0;
    bus.jr_target   = '0;
    bus.br_target   = '0;
    clr_redir();

    // reset values
    step(); step();
    chk("rst_pc", bus.pc_out, 32'h100);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_sel", {30'b0, bus.s1, bus.s0}, 32'd0);
    chk("rst_flush", {31'b0, bus.flush}, 32'd0);
    chk("rst_ready", {31'b0, bus.redir_ready}, 32'd1);

    // sequential run from RESET_PC
    rst_n  = 1'b1;
    bus.en = 1'b1;
    step();
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    chk("first_pc", bus.pc_out, 32'h100);
    fetch(1, 32'h104, 2'b00, 1'b0);
    fetch(1, 32'h108, 2'b00, 1'b0);

    // jump in the ack cycle, low bits forced to 00
    bus.jump_valid = 1'b1; bus.jump_target = 32'h2003;
    fetch(0, 32'h2000, 2'b11, 1'b1);
    clr_redir();
    step();
    chk("jump_flush_1cyc", {31'b0, bus.flush}, 32'd0);
    chk("sel_hold", {30'b0, bus.s1, bus.s0}, 32'd3);

    // taken branch two cycles before a delayed ack
    bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h400;
    step();
    clr_redir();
    chk("br_ready_lo0", {31'b0, bus.redir_ready}, 32'd0);
    step();
    chk("br_ready_lo1", {31'b0, bus.redir_ready}, 32'd0);
    fetch(0, 32'h400, 2'b01, 1'b1);
    chk("br_ready_hi", {31'b0, bus.redir_ready}, 32'd1);

    // not-taken branch is consumed with no effect
    bus.br_valid = 1'b1; bus.br_taken = 1'b0; bus.br_target = 32'h700;
    step();
    clr_redir();
    chk("nt_ready", {31'b0, bus.redir_ready}, 32'd1);
    fetch(0, 32'h404, 2'b00, 1'b0);

    // priority: jump beats jr and branch; jr held off while pending full
    bus.jump_valid = 1'b1; bus.jump_target = 32'h3000;
    bus.jr_valid   = 1'b1; bus.jr_target   = 32'h800;
    bus.br_valid   = 1'b1; bus.br_taken    = 1'b1; bus.br_target = 32'h600;
    step();
    bus.jump_valid = 1'b0; bus.br_valid = 1'b0; bus.br_taken = 1'b0;
    chk("prio_ready_lo", {31'b0, bus.redir_ready}, 32'd0);
    step();
    chk("held_ready_lo", {31'b0, bus.redir_ready}, 32'd0);
    fetch(0, 32'h3000, 2'b11, 1'b1);
    chk("jr_offer_ready", {31'b0, bus.redir_ready}, 32'd1);
    step();
    clr_redir();
    chk("jr_pend_ready", {31'b0, bus.redir_ready}, 32'd0);
    fetch(0, 32'h800, 2'b10, 1'b1);

    // PC+4 wrap
    bus.jump_valid = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
    fetch(0, 32'hFFFF_FFFC, 2'b11, 1'b1);
    clr_redir();
    fetch(0, 32'h0000_0000, 2'b00, 1'b0);

    // drop en mid-fetch: one more update, then IDLE
    step();
    bus.en = 1'b0;
    fetch(0, 32'h4, 2'b00, 1'b0);
    chk("idle_req", {31'b0, bus.imem_req}, 32'd0);
    step();
    chk("idle_req2", {31'b0, bus.imem_req}, 32'd0);
    chk("idle_pc", bus.pc_out, 32'h4);

    // redirect while IDLE applies one cycle later without a fetch
    bus.jr_valid = 1'b1; bus.jr_target = 32'h903;
    step();
    clr_redir();
    chk("idle_pend_ready", {31'b0, bus.redir_ready}, 32'd0);
    chk("idle_pend_pc", bus.pc_out, 32'h4);
    step();
    chk("idle_redir_pc", bus.pc_out, 32'h900);
    chk("idle_redir_sel", {30'b0, bus.s1, bus.s0}, 32'd2);
    chk("idle_redir_flush", {31'b0, bus.flush}, 32'd1);
    chk("idle_redir_ready", {31'b0, bus.redir_ready}, 32'd1);
    chk("idle_redir_req", {31'b0, bus.imem_req}, 32'd0);
    step();
    chk("idle_flush_end", {31'b0, bus.flush}, 32'd0);

    // async reset mid-fetch with a pending redirect
    bus.en = 1'b1;
    step();
    chk("pre_rst_req", {31'b0, bus.imem_req}, 32'd1);
    bus.jump_valid = 1'b1; bus.jump_target = 32'h5000;
    step();
    clr_redir();
    chk("pre_rst_pend", {31'b0, bus.redir_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("arst_pc", bus.pc_out, 32'h100);
    chk("arst_ready", {31'b0, bus.redir_ready}, 32'd1);
    chk("arst_sel", {30'b0, bus.s1, bus.s0}, 32'd0);
    chk("arst_flush", {31'b0, bus.flush}, 32'd0);
    step();
    bus.en       = 1'b0;
    bus.imem_ack = 1'b1;
    rst_n        = 1'b1;
    step();
    chk("stale_ack_pc", bus.pc_out, 32'h100);
    chk("stale_ack_req", {31'b0, bus.imem_req}, 32'd0);
    bus.imem_ack = 1'b0;
    bus.en       = 1'b1;
    step();
    chk("post_rst_pc", bus.pc_out, 32'h100);
    fetch(1, 32'h104, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
